// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpnew_pkg
// Brief  : Shared FPU types and the round-robin pointer helper.
// Rev    : 1.0  initial release
// ============================================================================
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : fpnew_rr_pick
// Brief  : Combinational priority pick starting at a pointer, wrapping around.
// Rev    : 1.0  initial release
// ============================================================================
module fpnew_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  // One extra bit holds ptr+offset before the wrap correction.
  logic [IDX_W:0] w_cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_valid && req[w_cand[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpnew_slice_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fpnew_slice_result_arbiter
// Brief  : Round-robin merge of format-slice results into one output register.
// Rev    : 1.0  initial release
// ============================================================================
module fpnew_slice_result_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = 4,
  parameter int unsigned Width     = 64,
  parameter type         TagType   = logic,
  localparam int unsigned C_IDX_W  = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumSlices-1:0][Width-1:0]     slice_result_i,
  input  status_t [NumSlices-1:0]             slice_status_i,
  input  logic [NumSlices-1:0]                slice_ext_bit_i,
  input  TagType [NumSlices-1:0]              slice_tag_i,
  input  logic [NumSlices-1:0]                slice_valid_i,
  output logic [NumSlices-1:0]                slice_ready_o,
  input  logic [NumSlices-1:0]                slice_busy_i,
  input  logic                                flush_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output logic                                extension_bit_o,
  output TagType                              tag_o,
  output logic [C_IDX_W-1:0]                  out_slice_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o
);

  logic               w_can_load;
  logic               w_gnt_valid;
  logic [C_IDX_W-1:0] w_gnt_idx;
  logic               w_grant;
  logic [C_IDX_W-1:0] w_ptr;

  logic               r_valid;
  logic [Width-1:0]   r_result;
  status_t            r_status;
  logic               r_ext;
  TagType             r_tag;
  logic [C_IDX_W-1:0] r_slice;

  fpnew_rr_pick #(
    .NUM_REQ (NumSlices),
    .IDX_W   (C_IDX_W)
  ) u_pick (
    .req       (slice_valid_i),
    .ptr       (w_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_can_load = ~r_valid | out_ready_i;
  // Flush suppresses the grant so the pointer and the slices stay untouched.
  assign w_grant    = w_can_load & ~flush_i & w_gnt_valid;

  always_comb begin
    slice_ready_o = '0;
    if (w_grant) slice_ready_o[w_gnt_idx] = 1'b1;
  end

  generate
    if (NumSlices > 1) begin : g_ptr_reg
      logic [C_IDX_W-1:0] r_ptr;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_ptr <= '0;
        end else if (w_grant) begin
          r_ptr <= C_IDX_W'(rr_next(32'(w_gnt_idx), NumSlices));
        end
      end
      assign w_ptr = r_ptr;
    end else begin : g_ptr_const
      assign w_ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_status <= '0;
      r_ext    <= 1'b0;
      r_tag    <= '0;
      r_slice  <= '0;
    end else if (flush_i) begin
      r_valid  <= 1'b0;
    end else if (w_can_load) begin
      r_valid  <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_result <= slice_result_i[w_gnt_idx];
        r_status <= slice_status_i[w_gnt_idx];
        r_ext    <= slice_ext_bit_i[w_gnt_idx];
        r_tag    <= slice_tag_i[w_gnt_idx];
        r_slice  <= w_gnt_idx;
      end
    end
  end

  assign result_o        = r_result;
  assign status_o        = r_status;
  assign extension_bit_o = r_ext;
  assign tag_o           = r_tag;
  assign out_slice_o     = r_slice;
  assign out_valid_o     = r_valid;
  assign busy_o          = r_valid | (|slice_busy_i);

endmodule
`default_nettype wire

// File: tb/tb_fpnew_slice_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fpnew_slice_result_arbiter
// Brief  : Directed scoreboard bench for the slice result arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fpnew_slice_result_arbiter;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;
  typedef struct packed {
    logic [63:0] res;
    status_t     st;
    logic        ext;
    tag_t        tag;
    logic [1:0]  idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0][63:0]  s_res = '0;
  status_t [3:0]     s_st = '0;
  logic [3:0]        s_ext = '0;
  tag_t [3:0]        s_tag = '0;
  logic [3:0]        s_valid = '0;
  logic [3:0]        s_ready;
  logic [3:0]        s_busy = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b1;
  logic [63:0]       result;
  status_t           status;
  logic              ext_bit;
  tag_t              tag;
  logic [1:0]        out_slice;
  logic              out_valid;
  logic              busy;

  exp_t q[$];
  exp_t m_exp;
  exp_t m_got;
  int   n_vec = 0;
  int   n_err = 0;
  int   gen[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  fpnew_slice_result_arbiter #(
    .NumSlices (4),
    .Width     (64),
    .TagType   (tag_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .slice_result_i  (s_res),
    .slice_status_i  (s_st),
    .slice_ext_bit_i (s_ext),
    .slice_tag_i     (s_tag),
    .slice_valid_i   (s_valid),
    .slice_ready_o   (s_ready),
    .slice_busy_i    (s_busy),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status),
    .extension_bit_o (ext_bit),
    .tag_o           (tag),
    .out_slice_o     (out_slice),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy)
  );

  // Monitor: every accepted output must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      m_got = {result, status, ext_bit, tag, out_slice};
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", m_got);
      end else begin
        m_exp = q.pop_front();
        if (m_got !== m_exp) begin
          n_err++;
          $display("FAIL output_slice%0d: got %h expected %h", m_exp.idx, m_got, m_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gen_res(input int s, input int g);
    return {32'h4000_0000 + 32'(s), 32'(g)};
  endfunction

  task automatic set_slice(input int s);
    s_res[s] = gen_res(s, gen[s]);
    s_tag[s] = 4'(s + 4 * gen[s]);
    s_st[s]  = status_t'(5'(1 << s));
    s_ext[s] = 1'(gen[s]);
  endtask

  task automatic push(input int s);
    q.push_back({s_res[s], s_st[s], s_ext[s], s_tag[s], 2'(s)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outputs", {result ^ 64'(status) ^ 64'(ext_bit) ^ 64'(tag) ^ 64'(out_slice)}, 64'd0);

    // 2: single slice 2
    step();
    s_res[2] = 64'h3FF0_0000_0000_0000;
    s_tag[2] = 4'h5;
    s_st[2]  = status_t'(5'b00001);
    s_ext[2] = 1'b1;
    s_valid  = 4'b0100;
    push(2);
    @(negedge clk);
    chk("t2_ready", 64'(s_ready), 64'h4);
    step();
    s_valid = 4'b0000;
    @(negedge clk);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_slice", 64'(out_slice), 64'd2);
    chk("t2_result", result, 64'h3FF0_0000_0000_0000);

    // ptr is 3: grant slice 3 once to bring it back to 0
    step();
    set_slice(3);
    s_valid = 4'b1000;
    push(3);
    @(negedge clk);
    chk("t2_bubble", 64'(out_valid), 64'd0);
    chk("t2_ptr3", 64'(s_ready), 64'h8);
    step();
    gen[3]++;

    // 3: all slices valid continuously, grant order 0,1,2,3,0
    for (int s = 0; s < 4; s++) set_slice(s);
    s_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      push(c % 4);
      @(negedge clk);
      chk($sformatf("t3_ready_c%0d", c), 64'(s_ready), 64'(4'b0001 << (c % 4)));
      if (c > 0) chk($sformatf("t3_valid_c%0d", c), 64'(out_valid), 64'd1);
      step();
      gen[c % 4]++;
      set_slice(c % 4);
    end

    // 4: back-pressure with slice 1 waiting
    s_valid   = 4'b0010;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t4_ready_c%0d", c), 64'(s_ready), 64'd0);
      chk($sformatf("t4_hold_c%0d", c), result, gen_res(0, 1));
      step();
    end
    out_ready = 1'b1;
    push(1);
    @(negedge clk);
    chk("t4_drain_grant", 64'(s_ready), 64'h2);
    step();
    gen[1]++;
    set_slice(1);
    set_slice(0);

    // 5: flush with slice 0 and 1 valid; the held slice 1 result is killed
    s_valid   = 4'b0011;
    flush     = 1'b1;
    out_ready = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("t4_no_bubble", 64'(out_valid), 64'd1);
    chk("t5_flush_ready", 64'(s_ready), 64'd0);
    step();
    flush     = 1'b0;
    out_ready = 1'b1;
    push(0);
    @(negedge clk);
    chk("t5_flushed", 64'(out_valid), 64'd0);
    chk("t5_ptr_kept", 64'(s_ready), 64'h1);
    step();
    gen[0]++;
    set_slice(0);
    s_valid = 4'b0010;
    push(1);
    @(negedge clk);
    chk("t5_next", 64'(s_ready), 64'h2);
    step();
    s_valid = 4'b0000;
    @(negedge clk);

    // 6: busy and asynchronous reset
    step();
    s_busy = 4'b0100;
    @(negedge clk);
    chk("t6_valid_idle", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd1);
    step();
    s_busy = 4'b0000;
    @(negedge clk);
    chk("t6_not_busy", 64'(busy), 64'd0);
    step();
    out_ready = 1'b0;
    set_slice(2);
    s_valid = 4'b0100;
    step();
    s_valid = 4'b0000;
    @(negedge clk);
    chk("t6_loaded", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_result", result, 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    set_slice(0);
    set_slice(3);
    s_valid = 4'b1001;
    push(0);
    @(negedge clk);
    chk("t6_ptr_reset", 64'(s_ready), 64'h1);
    step();
    s_valid = 4'b0000;

    for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
